// File: rtl/peak_dpu_lsu.sv
// Load/store execution unit: one data-bus access per ld/st op, load extension for writeback,
// misalign detection and bus-error/timeout access faults. Single outstanding access.
module peak_dpu_lsu #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_req_vld,
  output logic        ls_req_rdy,
  input  logic [2:0]  ls_op,
  input  logic [31:0] ls_base,
  input  logic [31:0] ls_imm,
  input  logic [31:0] ls_st_data,
  input  logic [4:0]  ls_wr_addr,
  output logic        dbus_req_vld,
  input  logic        dbus_req_rdy,
  output logic [31:0] dbus_req_addr,
  output logic        dbus_req_we,
  output logic [3:0]  dbus_req_be,
  output logic [31:0] dbus_req_wdata,
  input  logic        dbus_rsp_vld,
  input  logic [31:0] dbus_rsp_rdata,
  input  logic        dbus_rsp_err,
  output logic        wb_vld,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        ls_done,
  output logic        ls_exc_vld,
  output logic [3:0]  ls_exc_code,
  output logic [31:0] ls_exc_addr
);

  localparam int unsigned CW = 16;
  localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LBU = 3'd3,
                         OP_LHU = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RSP, S_DONE, S_EXC} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [31:0]     ea_q, wdata_q, data_q;
  logic [3:0]      be_q;
  logic [4:0]      wr_addr_q;
  logic            fault_q;
  logic [CW-1:0]   cnt_q;

  logic [31:0] ea_c, wdata_c, lane_c, ext_c;
  logic [3:0]  be_c;
  logic        is_byte_c, is_half_c, is_word_c, misalign_c, accept_c, timeout_c, store_q_c;

  // Decode of the incoming op, evaluated only at accept
  always_comb begin
    ea_c      = ls_base + ls_imm;
    is_byte_c = (ls_op == OP_LB) || (ls_op == OP_LBU) || (ls_op == OP_SB);
    is_half_c = (ls_op == OP_LH) || (ls_op == OP_LHU) || (ls_op == OP_SH);
    is_word_c = (ls_op == OP_LW) || (ls_op == OP_SW);
    misalign_c = (is_half_c && ea_c[0]) || (is_word_c && (ea_c[1:0] != 2'b00));
    be_c      = 4'b1111;
    wdata_c   = ls_st_data;
    if (is_byte_c) begin
      be_c    = 4'b0001 << ea_c[1:0];
      wdata_c = {4{ls_st_data[7:0]}};
    end else if (is_half_c) begin
      be_c    = ea_c[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{ls_st_data[15:0]}};
    end
    accept_c  = ls_req_vld && (state == S_IDLE);
    timeout_c = cnt_q >= CW'(TO_CYC - 1);
    store_q_c = op_q >= OP_SB;
  end

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    lane_c = dbus_rsp_rdata >> {ea_q[1:0], 3'b000};
    case (op_q)
      OP_LB:   ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
      OP_LH:   ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
      OP_LBU:  ext_c = {24'd0, lane_c[7:0]};
      OP_LHU:  ext_c = {16'd0, lane_c[15:0]};
      default: ext_c = dbus_rsp_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept_c) state_nxt = misalign_c ? S_EXC : S_REQ;
      S_REQ:  if (dbus_req_rdy) state_nxt = S_RSP;
              else if (timeout_c) state_nxt = S_DONE;
      S_RSP:  if (dbus_rsp_vld || timeout_c) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Op context, timeout counter and captured load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= 3'd0;
      ea_q      <= 32'd0;
      wdata_q   <= 32'd0;
      data_q    <= 32'd0;
      be_q      <= 4'd0;
      wr_addr_q <= 5'd0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept_c) begin
        op_q      <= ls_op;
        ea_q      <= ea_c;
        wdata_q   <= wdata_c;
        be_q      <= be_c;
        wr_addr_q <= ls_wr_addr;
        fault_q   <= 1'b0;
        cnt_q     <= '0;
      end
      if (state == S_REQ || state == S_RSP) cnt_q <= cnt_q + CW'(1);
      if (state == S_REQ && !dbus_req_rdy && timeout_c) fault_q <= 1'b1;
      if (state == S_RSP) begin
        if (dbus_rsp_vld) begin
          data_q  <= ext_c;
          fault_q <= dbus_rsp_err;
        end else if (timeout_c) begin
          fault_q <= 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from the state register and the registered op context
  assign ls_req_rdy     = (state == S_IDLE);
  assign dbus_req_vld   = (state == S_REQ);
  assign dbus_req_addr  = dbus_req_vld ? {ea_q[31:2], 2'b00} : 32'd0;
  assign dbus_req_we    = dbus_req_vld && store_q_c;
  assign dbus_req_be    = dbus_req_vld ? be_q : 4'd0;
  assign dbus_req_wdata = dbus_req_vld ? wdata_q : 32'd0;
  assign ls_done        = (state == S_DONE) || (state == S_EXC);
  assign ls_exc_vld     = (state == S_EXC) || ((state == S_DONE) && fault_q);
  assign ls_exc_code    = (state == S_EXC) ? (store_q_c ? 4'd6 : 4'd4) :
                          ls_exc_vld       ? (store_q_c ? 4'd7 : 4'd5) : 4'd0;
  assign ls_exc_addr    = ls_exc_vld ? ea_q : 32'd0;
  assign wb_vld         = (state == S_DONE) && !fault_q && !store_q_c && (wr_addr_q != 5'd0);
  assign wb_addr        = wb_vld ? wr_addr_q : 5'd0;
  assign wb_data        = wb_vld ? data_q : 32'd0;

endmodule
